// File: rtl/if_id_queue_pkg.sv
// ----------------------------------------------------------------------------
// if_id_queue_pkg
// Shared constants and types for the fetch-to-decode instruction queue.
//   IQ_DEPTH_DEFAULT : default number of queue entries
//   NOP_INSTR        : instruction word presented while the queue is empty
//   RESET_PC         : architectural reset PC of the core
//   iq_entry_t       : one queue entry {pc, instr, misalign}, 65 bits
// ----------------------------------------------------------------------------
package if_id_queue_pkg;

    localparam int          IQ_DEPTH_DEFAULT = 4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] RESET_PC         = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        misalign;
    } iq_entry_t;

    // A fetch PC is misaligned when it is not on a 4-byte boundary.
    function automatic logic pc_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/iq_storage.sv
// ----------------------------------------------------------------------------
// iq_storage
// DEPTH x 65-bit entry array for the instruction queue. One synchronous
// write port, one asynchronous read port. No reset: stale contents are
// masked by the occupancy count in the parent.
//   clk     : clock
//   wr_en   : write wr_data into slot wr_addr on the rising edge
//   wr_addr : write slot index
//   wr_data : entry to store
//   rd_addr : read slot index
//   rd_data : entry held in slot rd_addr (combinational)
// ----------------------------------------------------------------------------
module iq_storage
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  iq_entry_t                wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output iq_entry_t                rd_data
);

    iq_entry_t mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/if_id_queue.sv
// ----------------------------------------------------------------------------
// if_id_queue
// In-order instruction queue between fetch and decode. Entries carry the PC,
// the instruction word and a misalignment flag captured at push time.
//   clk          : clock, rising edge
//   reset        : asynchronous active-low reset
//   in_valid     : fetch presents an instruction
//   in_ready     : queue can accept (not full)
//   in_pc        : PC of presented instruction
//   in_instr     : presented instruction word
//   flush        : redirect, discard all entries (highest priority)
//   out_valid    : head entry valid (not empty)
//   out_ready    : decode consumes the head entry
//   out_pc       : head PC (0 when empty)
//   out_instr    : head instruction (NOP when empty)
//   out_misalign : head PC misaligned (0 when empty)
//   count        : current occupancy
// ----------------------------------------------------------------------------
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_instr,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic                     out_misalign,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg,  count_next;

    logic      push;
    logic      pop;
    iq_entry_t wr_entry;
    iq_entry_t head_entry;

    // Handshake flags depend only on registered occupancy, so a pop on a
    // full queue never opens a push slot in the same cycle.
    assign in_ready  = (count_reg != CNT_FULL);
    assign out_valid = (count_reg != '0);

    assign push = in_valid && in_ready  && !flush;
    assign pop  = out_valid && out_ready && !flush;

    assign wr_entry.pc       = in_pc;
    assign wr_entry.instr    = in_instr;
    assign wr_entry.misalign = pc_misaligned(in_pc);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;

        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    iq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_reg),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_reg),
        .rd_data (head_entry)
    );

    // Storage is never read while empty; present a harmless NOP instead.
    assign out_pc       = out_valid ? head_entry.pc       : 32'h0;
    assign out_instr    = out_valid ? head_entry.instr    : NOP_INSTR;
    assign out_misalign = out_valid ? head_entry.misalign : 1'b0;
    assign count        = count_reg;

endmodule

// File: tb/tb_if_id_queue.sv
// ----------------------------------------------------------------------------
// tb_if_id_queue
// Directed testbench for if_id_queue (DEPTH=4).
// ----------------------------------------------------------------------------
module tb_if_id_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_misalign;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_id_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_misalign (out_misalign),
        .count        (count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %-24s got %08h expected %08h", tag, obs, exp);
        end else begin
            $display("ok   %-24s %08h", tag, obs);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0013;
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic drive_push(input logic [31:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr_of(pc);
    endtask

    logic [31:0] exp_pops [10] = '{
        32'h8000_0008, 32'h8000_000C, 32'h8000_0100, 32'h8000_0104, 32'h8000_0108,
        32'h8000_010C, 32'h8000_0110, 32'h8000_0114, 32'h8000_0118, 32'h8000_011C
    };

    initial begin
        reset     = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        idle();

        // Reset state
        #2;
        check("rst_in_ready",   32'(in_ready),     32'd1);
        check("rst_out_valid",  32'(out_valid),    32'd0);
        check("rst_out_pc",     out_pc,            32'h0);
        check("rst_out_instr",  out_instr,         32'h0000_0013);
        check("rst_misalign",   32'(out_misalign), 32'd0);
        check("rst_count",      32'(count),        32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Three pushes with decode stalled
        for (int i = 0; i < 3; i++) begin
            drive_push(32'h8000_0000 + 32'(4 * i));
            if (i == 0) begin
                #1;
                check("no_bypass_valid", 32'(out_valid), 32'd0);
            end
            tick();
        end
        idle();
        check("push3_count",    32'(count),     32'd3);
        check("push3_out_pc",   out_pc,         32'h8000_0000);
        check("push3_out_instr", out_instr,     instr_of(32'h8000_0000));
        check("push3_in_ready", 32'(in_ready),  32'd1);

        // Fill, then offer a push together with a pop while full
        drive_push(32'h8000_000C);
        tick();
        idle();
        check("full_count",     32'(count),     32'd4);
        check("full_in_ready",  32'(in_ready),  32'd0);
        drive_push(32'h8000_0010);
        out_ready = 1'b1;
        #1;
        check("full_pop_ready", 32'(in_ready),  32'd0);
        check("full_pop_head",  out_pc,         32'h8000_0000);
        tick();
        idle();
        check("full_pop_count", 32'(count),     32'd3);
        check("full_pop_next",  out_pc,         32'h8000_0004);

        // Drop to two entries
        out_ready = 1'b1;
        tick();
        idle();
        check("pop_to2_count",  32'(count),     32'd2);
        check("pop_to2_head",   out_pc,         32'h8000_0008);

        // Ten cycles of simultaneous push and pop; pointers wrap repeatedly
        for (int i = 0; i < 10; i++) begin
            drive_push(32'h8000_0100 + 32'(4 * i));
            out_ready = 1'b1;
            #1;
            check($sformatf("stream_pc[%0d]", i), out_pc, exp_pops[i]);
            check($sformatf("stream_in[%0d]", i), out_instr, instr_of(exp_pops[i]));
            tick();
            check($sformatf("stream_cnt[%0d]", i), 32'(count), 32'd2);
        end
        idle();
        check("stream_head_after", out_pc,      32'h8000_0120);

        // Flush with a competing push and pop
        drive_push(32'h8000_0200);
        tick();
        idle();
        check("preflush_count", 32'(count),     32'd3);
        drive_push(32'h8000_0300);
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        idle();
        check("flush_count",    32'(count),     32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_out_instr", out_instr,     32'h0000_0013);
        check("flush_out_pc",   out_pc,         32'h0);
        tick();
        check("flush_no_push",  32'(count),     32'd0);

        // Misaligned PC reaches the head
        drive_push(32'h8000_0004);
        tick();
        drive_push(32'h8000_0002);
        tick();
        idle();
        check("align_head_flag", 32'(out_misalign), 32'd0);
        check("align_head_pc",  out_pc,         32'h8000_0004);
        out_ready = 1'b1;
        tick();
        idle();
        check("misalign_pc",    out_pc,         32'h8000_0002);
        check("misalign_flag",  32'(out_misalign), 32'd1);
        check("misalign_instr", out_instr,      instr_of(32'h8000_0002));
        out_ready = 1'b1;
        tick();
        idle();
        check("drain_count",    32'(count),     32'd0);

        // Asynchronous reset between edges with two entries queued
        drive_push(32'h8000_00A0);
        tick();
        drive_push(32'h8000_00A4);
        tick();
        idle();
        check("prerst_count",   32'(count),     32'd2);
        #2;
        reset = 1'b0;
        #1;
        check("arst_count",     32'(count),     32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_instr", out_instr,      32'h0000_0013);
        check("arst_in_ready",  32'(in_ready),  32'd1);
        #2;
        reset = 1'b1;
        tick();
        check("postrst_count",  32'(count),     32'd0);
        drive_push(32'h8000_00B0);
        tick();
        idle();
        check("postrst_push_pc", out_pc,        32'h8000_00B0);
        check("postrst_push_cnt", 32'(count),   32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
